// File: rtl/layer_sequencer.sv
// Sequences one model pass (forward, then optional backward) from the layer tables onto the compute engine.
// Latency: 1 fetch cycle per op (2 for backward ops with idx > 0), then issue, then wait for op_done.
// Backpressure: op_* fields are held while op_valid && !op_ready; only one op is outstanding at a time.

package layer_seq_pkg;
   typedef logic [31:0] mem_handle_t;
   // Layers with this opcode have no weight/bias table entries.
   localparam logic [7:0] OP_FLATTEN = 8'h04;
endpackage

module layer_sequencer
   import layer_seq_pkg::*;
#(
   parameter int MAX_LAYERS = 16,
   parameter int LIDX_W     = 4
) (
   input  logic              clk,
   input  logic              rst_l,
   input  logic              start,
   input  logic              train,
   input  logic [LIDX_W:0]   num_layers,
   input  mem_handle_t       sample_ptr,
   input  logic              abort,
   output logic [LIDX_W-1:0] tbl_idx,
   input  logic [7:0]        tbl_opcode,
   input  mem_handle_t       tbl_scratch,
   input  mem_handle_t       tbl_weight,
   input  mem_handle_t       tbl_wgrad,
   input  mem_handle_t       tbl_bias,
   input  mem_handle_t       tbl_bgrad,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [7:0]        op_opcode,
   output logic              op_bwd,
   output mem_handle_t       op_in,
   output mem_handle_t       op_out,
   output mem_handle_t       op_weight,
   output mem_handle_t       op_bias,
   input  logic              op_done,
   output logic              busy,
   output logic              pass_done,
   output logic              pass_err
);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_FINISH} state_t;

   localparam logic [LIDX_W:0]   ONE   = (LIDX_W+1)'(1);
   localparam logic [LIDX_W-1:0] ONE_S = LIDX_W'(1);
   localparam logic [LIDX_W:0]   MAXL  = (LIDX_W+1)'(MAX_LAYERS);

   state_t          state, state_nxt;
   logic [LIDX_W:0] idx;        // wide enough that 16 layers never wraps
   logic [LIDX_W:0] nl_q;
   logic            dir_bwd;
   logic            train_q;
   logic            fetch2;     // second backward fetch cycle: reads scratch[idx-1]
   mem_handle_t     sample_q;
   mem_handle_t     prev_q;     // scratch handle of the previous forward layer

   logic start_ok;
   logic last_fwd;
   logic fetch_more;
   logic is_flat;

   assign start_ok   = start && (num_layers != '0) && (num_layers <= MAXL);
   assign last_fwd   = (idx == (nl_q - ONE));
   assign fetch_more = dir_bwd && (idx != '0) && !fetch2;
   assign is_flat    = (tbl_opcode == OP_FLATTEN);

   // State register.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode plus the outputs that follow directly from the state.
   always_comb begin
      state_nxt = state;
      op_valid  = 1'b0;
      busy      = (state != S_IDLE);
      tbl_idx   = '0;
      case (state)
         S_IDLE: begin
            if (start_ok) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            tbl_idx = fetch2 ? (idx[LIDX_W-1:0] - ONE_S) : idx[LIDX_W-1:0];
            if (!fetch_more) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            op_valid = 1'b1;
            if (op_ready) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (op_done) begin
               if (dir_bwd)       state_nxt = (idx == '0) ? S_FINISH : S_FETCH;
               else if (last_fwd) state_nxt = train_q ? S_FETCH : S_FINISH;
               else               state_nxt = S_FETCH;
            end
         end
         S_FINISH: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
      // Cancel wins over everything, including a same-cycle op_done.
      if (abort && (state != S_IDLE)) state_nxt = S_IDLE;
   end

   // Pass context, layer walk, table capture and the pass_done/pass_err pulses.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         idx       <= '0;
         nl_q      <= '0;
         dir_bwd   <= 1'b0;
         train_q   <= 1'b0;
         fetch2    <= 1'b0;
         sample_q  <= '0;
         prev_q    <= '0;
         op_opcode <= '0;
         op_bwd    <= 1'b0;
         op_in     <= '0;
         op_out    <= '0;
         op_weight <= '0;
         op_bias   <= '0;
         pass_done <= 1'b0;
         pass_err  <= 1'b0;
      end else begin
         pass_done <= 1'b0;
         pass_err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  train_q  <= train;
                  nl_q     <= num_layers;
                  sample_q <= sample_ptr;
                  idx      <= '0;
                  dir_bwd  <= 1'b0;
                  fetch2   <= 1'b0;
               end else if (start) begin
                  pass_done <= 1'b1;
                  pass_err  <= 1'b1;
               end
            end
            S_FETCH: begin
               if (!fetch2) begin
                  op_opcode <= tbl_opcode;
                  op_bwd    <= dir_bwd;
                  op_out    <= tbl_scratch;
                  op_weight <= is_flat ? '0 : (dir_bwd ? tbl_wgrad : tbl_weight);
                  op_bias   <= is_flat ? '0 : (dir_bwd ? tbl_bgrad : tbl_bias);
                  if (!dir_bwd) begin
                     op_in  <= (idx == '0) ? sample_q : prev_q;
                     prev_q <= tbl_scratch;
                  end else if (idx == '0) begin
                     op_in  <= sample_q;
                  end
                  fetch2 <= fetch_more;
               end else begin
                  op_in  <= tbl_scratch;
                  fetch2 <= 1'b0;
               end
            end
            S_WAIT: begin
               if (op_done && !abort) begin
                  if (dir_bwd) begin
                     if (idx != '0) idx <= idx - ONE;
                  end else if (last_fwd) begin
                     if (train_q) dir_bwd <= 1'b1;
                  end else begin
                     idx <= idx + ONE;
                  end
               end
            end
            S_FINISH: pass_done <= 1'b1;
            default: ;
         endcase
         if (abort && (state != S_IDLE)) pass_done <= 1'b1;
      end
   end

endmodule
